// File: rtl/ofdm_sc_scheduler_pkg.sv
// Shared types and helpers for the OFDM subcarrier scheduler and its s_to_p consumer.
// The bin classification lives here so other OFDM blocks can agree on the same map.
package ofdm_pkg;

   localparam int SAMPLE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA
   } state_e;

   typedef enum logic [1:0] {
      SC_GUARD,
      SC_PILOT,
      SC_DATA
   } sc_class_e;

   // Priority order: guard edges and DC first, then pilot comb, else payload.
   // The stride must be a power of two so the modulo reduces to a mask.
   function automatic sc_class_e classify(input int k, input int n_sc, input int guard_lo,
                                          input int guard_hi, input int stride, input int offset);
      sc_class_e cls;
      if (k < guard_lo || k > n_sc - 1 - guard_hi || k == n_sc / 2)
         cls = SC_GUARD;
      else if ((k & (stride - 1)) == offset)
         cls = SC_PILOT;
      else
         cls = SC_DATA;
      return cls;
   endfunction

endpackage

// File: rtl/ofdm_sc_scheduler_sc_classifier.sv
// Combinational bin classifier: maps subcarrier index and frame state to a bin
// class and, for internally generated bins, the sample value to emit.
module sc_classifier
   import ofdm_pkg::*;
#(
   parameter int                N_SC         = 64,
   parameter int                WIDTH        = SAMPLE_W,
   parameter int                GUARD_LO     = 6,
   parameter int                GUARD_HI     = 5,
   parameter int                PILOT_STRIDE = 8,
   parameter int                PILOT_OFFSET = 2,
   parameter logic [WIDTH-1:0]  PILOT_VAL    = 'h40,
   parameter logic [WIDTH-1:0]  PREAMBLE_VAL = 'h5A,
   parameter int                K_W          = $clog2(N_SC)
) (
   input  logic [K_W-1:0]   k,
   input  state_e           state,
   input  logic             s_odd,
   output sc_class_e        cls,
   output logic             gen,
   output logic [WIDTH-1:0] value
);

   logic signed [WIDTH-1:0] pilot_pos;
   logic signed [WIDTH-1:0] pilot_neg;

   assign pilot_pos = PILOT_VAL;
   assign pilot_neg = -pilot_pos;

   always_comb begin
      cls   = classify(int'(32'(k)), N_SC, GUARD_LO, GUARD_HI, PILOT_STRIDE, PILOT_OFFSET);
      // Only payload bins during data symbols come from the input stream.
      gen   = (state != ST_DATA) || (cls != SC_DATA);
      value = '0;
      if (cls != SC_GUARD) begin
         if (state == ST_PREAMBLE)
            value = k[0] ? '0 : PREAMBLE_VAL;
         else if (state == ST_DATA && cls == SC_PILOT)
            value = s_odd ? pilot_pos : pilot_neg;
      end
   end

endmodule

// File: rtl/ofdm_sc_scheduler.sv
// OFDM frame scheduler: walks subcarriers per symbol and muxes guard, pilot,
// preamble and payload samples onto the single serial stream feeding s_to_p.
module ofdm_sc_scheduler
   import ofdm_pkg::*;
#(
   parameter int                N_SC           = 64,
   parameter int                WIDTH          = SAMPLE_W,
   parameter int                GUARD_LO       = 6,
   parameter int                GUARD_HI       = 5,
   parameter int                PILOT_STRIDE   = 8,
   parameter int                PILOT_OFFSET   = 2,
   parameter logic [WIDTH-1:0]  PILOT_VAL      = 'h40,
   parameter logic [WIDTH-1:0]  PREAMBLE_VAL   = 'h5A,
   parameter int                SYMS_PER_FRAME = 4,
   localparam int               K_W            = $clog2(N_SC),
   localparam int               S_W            = $clog2(SYMS_PER_FRAME + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             o_ready,
   output logic             o_sof,
   output logic             o_last,
   output logic [S_W-1:0]   o_sym_idx,
   output logic             o_busy
);

   state_e           state, state_n;
   logic [K_W-1:0]   k, k_n;
   logic [S_W-1:0]   s, s_n;
   sc_class_e        cls;
   logic             gen;
   logic [WIDTH-1:0] gen_val;
   logic             can_load;
   logic             load;
   logic             last_bin;
   logic             last_sym;
   logic             final_q;

   sc_classifier #(
      .N_SC         (N_SC),
      .WIDTH        (WIDTH),
      .GUARD_LO     (GUARD_LO),
      .GUARD_HI     (GUARD_HI),
      .PILOT_STRIDE (PILOT_STRIDE),
      .PILOT_OFFSET (PILOT_OFFSET),
      .PILOT_VAL    (PILOT_VAL),
      .PREAMBLE_VAL (PREAMBLE_VAL),
      .K_W          (K_W)
   ) u_classifier (
      .k     (k),
      .state (state),
      .s_odd (s[0]),
      .cls   (cls),
      .gen   (gen),
      .value (gen_val)
   );

   always_comb begin
      can_load = !o_valid || o_ready;
      load     = (state != ST_IDLE) && can_load && (gen || i_valid);
      i_ready  = (state == ST_DATA) && (cls == SC_DATA) && can_load;
      last_bin = (k == K_W'(N_SC - 1));
      last_sym = (state == ST_DATA) && (s == S_W'(SYMS_PER_FRAME));
      state_n  = state;
      k_n      = k;
      s_n      = s;
      case (state)
         // o_busy gates the start so a new frame cannot begin while the final beat is still pending.
         ST_IDLE: begin
            if (i_start && !o_busy)
               state_n = ST_PREAMBLE;
         end
         ST_PREAMBLE, ST_DATA: begin
            if (load) begin
               if (last_bin) begin
                  k_n = '0;
                  if (last_sym) begin
                     state_n = ST_IDLE;
                     s_n     = '0;
                  end else begin
                     state_n = ST_DATA;
                     s_n     = s + S_W'(1);
                  end
               end else begin
                  k_n = k + K_W'(1);
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         k     <= '0;
         s     <= '0;
      end else begin
         state <= state_n;
         k     <= k_n;
         s     <= s_n;
      end
   end

   // Output register stage: sideband fields only change on a load, so they hold under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_sof     <= 1'b0;
         o_last    <= 1'b0;
         o_sym_idx <= '0;
         o_busy    <= 1'b0;
         final_q   <= 1'b0;
      end else if (load) begin
         o_valid   <= 1'b1;
         o_data    <= gen ? gen_val : i_data;
         o_sof     <= (state == ST_PREAMBLE) && (k == '0);
         o_last    <= last_bin;
         o_sym_idx <= s;
         o_busy    <= 1'b1;
         final_q   <= last_bin && last_sym;
      end else if (o_ready) begin
         o_valid <= 1'b0;
         if (o_valid && final_q) begin
            o_busy  <= 1'b0;
            final_q <= 1'b0;
         end
      end
   end

endmodule
